// File: rtl/peripheral.sv
// peripheral: memory-mapped timer, LED/switch/seven-segment registers and an 8N1 UART.
// Define PERIPHERAL_UART_RX_EN to build the UART receiver; without it RXD and RX-ready read 0.
module peripheral #(
   parameter int CLK_FREQ = 100000000,
   parameter int BAUD     = 9600
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic [7:0]  led,
   input  logic [7:0]  switch,
   output logic [11:0] digi,
   output logic        irqout,
   input  logic        PC_Uart_rxd,
   output logic        PC_Uart_txd
);
   localparam logic [31:0] BP_M1  = 32'(CLK_FREQ / BAUD - 1);
   localparam logic [31:0] A_TH   = 32'h4000_0000;
   localparam logic [31:0] A_TL   = 32'h4000_0004;
   localparam logic [31:0] A_TCON = 32'h4000_0008;
   localparam logic [31:0] A_LED  = 32'h4000_000C;
   localparam logic [31:0] A_SW   = 32'h4000_0010;
   localparam logic [31:0] A_DIGI = 32'h4000_0014;
   localparam logic [31:0] A_TXD  = 32'h4000_0018;
   localparam logic [31:0] A_RXD  = 32'h4000_001C;
   localparam logic [31:0] A_UCON = 32'h4000_0020;

   logic [31:0] r_th, r_tl, r_tx_cnt;
   logic [2:0]  r_tcon;
   logic [7:0]  r_led, w_rxd;
   logic [11:0] r_digi;
   logic [1:0]  r_ucon_ie;
   logic [9:0]  r_tx_frame;
   logic [3:0]  r_tx_bit;
   logic        r_tx_busy, r_tx_done, r_txd, w_rx_ready;

   always_comb begin
      rdata = '0;
      if (rd)
         case (addr)
            A_TH:    rdata = r_th;
            A_TL:    rdata = r_tl;
            A_TCON:  rdata = {29'd0, r_tcon};
            A_LED:   rdata = {24'd0, r_led};
            A_SW:    rdata = {24'd0, switch};
            A_DIGI:  rdata = {20'd0, r_digi};
            A_RXD:   rdata = {24'd0, w_rxd};
            A_UCON:  rdata = {27'd0, r_tx_busy, w_rx_ready, r_tx_done, r_ucon_ie};
            default: rdata = '0;
         endcase
   end

   // CPU writes to TL/TCON take priority over the timer's own update
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_th   <= '0;
         r_tl   <= '0;
         r_tcon <= '0;
      end else begin
         if (wr && addr == A_TH) r_th <= wdata;
         if (wr && addr == A_TL) r_tl <= wdata;
         else if (r_tcon[0]) r_tl <= (r_tl == '1) ? r_th : r_tl + 32'd1;
         if (wr && addr == A_TCON) r_tcon <= wdata[2:0];
         else if (r_tcon[0] && r_tcon[1] && r_tl == '1) r_tcon[2] <= 1'b1;
      end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_led     <= '0;
         r_digi    <= '0;
         r_ucon_ie <= '0;
      end else begin
         if (wr && addr == A_LED) r_led <= wdata[7:0];
         if (wr && addr == A_DIGI) r_digi <= wdata[11:0];
         if (wr && addr == A_UCON) r_ucon_ie <= wdata[1:0];
      end

   // Transmit: frame shifts out LSB first, start bit already on the line at the latching edge
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_tx_busy  <= 1'b0;
         r_tx_done  <= 1'b0;
         r_txd      <= 1'b1;
         r_tx_frame <= '0;
         r_tx_cnt   <= '0;
         r_tx_bit   <= '0;
      end else begin
         if (rd && addr == A_UCON) r_tx_done <= 1'b0;
         if (!r_tx_busy) begin
            if (wr && addr == A_TXD) begin
               r_tx_busy  <= 1'b1;
               r_tx_frame <= {1'b1, wdata[7:0], 1'b0};
               r_txd      <= 1'b0;
               r_tx_cnt   <= '0;
               r_tx_bit   <= '0;
            end
         end else if (r_tx_cnt != BP_M1) begin
            r_tx_cnt <= r_tx_cnt + 32'd1;
         end else begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 4'd9) begin
               r_tx_busy <= 1'b0;
               r_tx_done <= 1'b1;
               r_txd     <= 1'b1;
            end else begin
               r_tx_bit   <= r_tx_bit + 4'd1;
               r_tx_frame <= r_tx_frame >> 1;
               r_txd      <= r_tx_frame[1];
            end
         end
      end

`ifdef PERIPHERAL_UART_RX_EN
   localparam logic [31:0] HALF_M1 = 32'(CLK_FREQ / BAUD / 2 - 1);
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   rx_state_t   r_rx_st, w_rx_nst;
   logic        r_rx_s1, r_rx_s2, r_rx_prev, r_rx_ready, w_rx_tick, w_rx_done;
   logic [7:0]  r_rxd, r_rx_sh;
   logic [31:0] r_rx_cnt;
   logic [2:0]  r_rx_bit;

   assign w_rx_tick = r_rx_cnt == ((r_rx_st == RX_START) ? HALF_M1 : BP_M1);
   assign w_rx_done = r_rx_st == RX_STOP && w_rx_tick && r_rx_s2;

   always_comb begin
      w_rx_nst = r_rx_st;
      case (r_rx_st)
         RX_IDLE:  if (r_rx_prev && !r_rx_s2) w_rx_nst = RX_START;
         RX_START: if (w_rx_tick) w_rx_nst = r_rx_s2 ? RX_IDLE : RX_DATA;
         RX_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_nst = RX_STOP;
         RX_STOP:  if (w_rx_tick) w_rx_nst = RX_IDLE;
         default:  w_rx_nst = RX_IDLE;
      endcase
   end

   // Synchronizer flops idle high so a released reset on an idle line is not a start edge
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_rx_s1    <= 1'b1;
         r_rx_s2    <= 1'b1;
         r_rx_prev  <= 1'b1;
         r_rx_st    <= RX_IDLE;
         r_rx_cnt   <= '0;
         r_rx_bit   <= '0;
         r_rx_sh    <= '0;
         r_rxd      <= '0;
         r_rx_ready <= 1'b0;
      end else begin
         r_rx_s1   <= PC_Uart_rxd;
         r_rx_s2   <= r_rx_s1;
         r_rx_prev <= r_rx_s2;
         r_rx_st   <= w_rx_nst;
         r_rx_cnt  <= (r_rx_st == RX_IDLE || w_rx_tick) ? '0 : r_rx_cnt + 32'd1;
         if (r_rx_st == RX_DATA && w_rx_tick) begin
            r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
            r_rx_bit <= r_rx_bit + 3'd1;
         end
         if (w_rx_done) r_rxd <= r_rx_sh;
         if (w_rx_done) r_rx_ready <= 1'b1;
         else if (rd && addr == A_RXD) r_rx_ready <= 1'b0;
      end

   assign w_rxd      = r_rxd;
   assign w_rx_ready = r_rx_ready;
`else
   logic w_unused_rxd;
   assign w_unused_rxd = PC_Uart_rxd;
   assign w_rxd        = '0;
   assign w_rx_ready   = 1'b0;
`endif

   assign led         = r_led;
   assign digi        = r_digi;
   assign PC_Uart_txd = r_txd;
   assign irqout      = r_tcon[2] | (r_ucon_ie[0] & r_tx_done) | (r_ucon_ie[1] & w_rx_ready);
endmodule

// File: tb/tb_peripheral.sv
// tb_peripheral: randomized bench for peripheral against a register-level model of the map,
// timer, 8N1 transmitter and receiver.
module tb_peripheral;
   localparam int BP = 16;
   localparam logic [31:0] A_TH   = 32'h4000_0000;
   localparam logic [31:0] A_TL   = 32'h4000_0004;
   localparam logic [31:0] A_TCON = 32'h4000_0008;
   localparam logic [31:0] A_LED  = 32'h4000_000C;
   localparam logic [31:0] A_SW   = 32'h4000_0010;
   localparam logic [31:0] A_DIGI = 32'h4000_0014;
   localparam logic [31:0] A_TXD  = 32'h4000_0018;
   localparam logic [31:0] A_RXD  = 32'h4000_001C;
   localparam logic [31:0] A_UCON = 32'h4000_0020;
`ifdef PERIPHERAL_UART_RX_EN
   localparam bit RX_EN = 1'b1;
`else
   localparam bit RX_EN = 1'b0;
`endif

   logic        clk = 1'b0, reset = 1'b0, rd = 1'b0, wr = 1'b0, rxd = 1'b1;
   logic [31:0] addr = '0, wdata = '0, rdata;
   logic [7:0]  led, switch = '0;
   logic [11:0] digi;
   logic        irqout, txd;
   int          n_cmp = 0, n_err = 0;

   peripheral #(.CLK_FREQ(160), .BAUD(10)) dut (
      .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
      .rdata(rdata), .led(led), .switch(switch), .digi(digi), .irqout(irqout),
      .PC_Uart_rxd(rxd), .PC_Uart_txd(txd)
   );

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wr32(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      wr = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      wr = 1'b0; addr = '0; wdata = '0;
   endtask

   // Combinational peek: no clock edge sees rd=1, so no read side effects
   task automatic rd32(input logic [31:0] a, output logic [31:0] d);
      rd = 1'b1; addr = a;
      #1 d = rdata;
      rd = 1'b0; addr = '0;
   endtask

   // Read held across one edge so flag-clearing reads take effect
   task automatic rd_clr(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk);
      rd = 1'b1; addr = a;
      #1 d = rdata;
      @(negedge clk);
      rd = 1'b0; addr = '0;
   endtask

   task automatic tx_frame(input logic [7:0] b, input bit inject, input logic [1:0] ie);
      logic [9:0]  fr;
      logic [31:0] d;
      fr = {1'b1, b, 1'b0};
      wr32(A_UCON, {30'd0, ie});
      wr32(A_TXD, {24'hFF, b});
      rd32(A_UCON, d);
      check("tx_busy_set", d[4], 1'b1);
      for (int i = 0; i < 10; i++) begin
         if (inject && i == 4) begin
            repeat (BP - 2) @(negedge clk);
            wr32(A_TXD, 32'h55);
         end else begin
            repeat (i == 0 ? BP / 2 : BP) @(negedge clk);
         end
         check($sformatf("tx_bit%0d", i), txd, fr[i]);
      end
      repeat (BP / 2 - 1) @(negedge clk);
      rd32(A_UCON, d);
      check("tx_busy_last", d[4], 1'b1);
      check("tx_irq_pre", irqout, 1'b0);
      rd_clr(A_UCON, d);
      check("tx_done_busy", d[4:2], 3'b001);
      check("tx_irq", irqout, 1'b0);
      rd32(A_UCON, d);
      check("tx_done_clr", d[2], 1'b0);
      check("tx_ie", d[1:0], ie);
   endtask

   task automatic timer_run(input logic [31:0] th, input int k, input logic [2:0] tcon, input int j);
      logic [31:0] d;
      wr32(A_TCON, 32'h0);
      wr32(A_TH, th);
      wr32(A_TL, 32'hFFFF_FFFF - 32'(k));
      wr32(A_TCON, {29'd0, tcon});
      repeat (k) @(negedge clk);
      check("tmr_irq_pre", irqout, 1'b0);
      rd32(A_TL, d);
      check("tmr_tl_max", d, 32'hFFFF_FFFF);
      @(negedge clk);
      check("tmr_irq", irqout, tcon[1]);
      rd32(A_TL, d);
      check("tmr_reload", d, th);
      repeat (j) @(negedge clk);
      rd32(A_TL, d);
      check("tmr_count", d, th + 32'(j));
      rd32(A_TCON, d);
      check("tmr_tcon", d, {29'd0, tcon[1], tcon[1:0]});
      wr32(A_TL, 32'h100);
      rd32(A_TL, d);
      check("tmr_tl_wr_wins", d, 32'h100);
      wr32(A_TCON, 32'h0);
      rd32(A_TCON, d);
      check("tmr_tcon_wr_wins", d, 32'h0);
      check("tmr_irq_off", irqout, 1'b0);
   endtask

   task automatic rx_send(input logic [7:0] b, input logic stop);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rxd = fr[i];
         repeat (BP) @(negedge clk);
      end
      rxd = 1'b1;
      repeat (BP) @(negedge clk);
   endtask

   initial begin
      logic [31:0] d;
      logic [7:0]  m_led, m_rxd, b;
      logic [11:0] m_digi;
      logic [1:0]  ie;
      logic        m_ready, stop;
      m_led = '0; m_digi = '0; m_rxd = '0; m_ready = 1'b0;

      repeat (3) @(negedge clk);
      #1;
      check("rst_led", led, 8'h00);
      check("rst_digi", digi, 12'h000);
      check("rst_txd", txd, 1'b1);
      check("rst_irq", irqout, 1'b0);
      reset = 1'b1;
      foreach (A_TH[i]) begin end
      rd32(A_TH, d);   check("rst_th", d, 32'h0);
      rd32(A_TL, d);   check("rst_tl", d, 32'h0);
      rd32(A_TCON, d); check("rst_tcon", d, 32'h0);
      rd32(A_UCON, d); check("rst_ucon", d, 32'h0);

      // Register map, read-before-write and unmapped addresses
      for (int t = 0; t < 8; t++) begin
         logic [31:0] rw, rdg;
         rw = $urandom; rdg = $urandom;
         switch = 8'($urandom);
         if (t == 0) begin rw = 32'hA5; switch = 8'h3C; end
         @(negedge clk);
         rd = 1'b1; wr = 1'b1; addr = A_LED; wdata = rw;
         #1 check("led_rd_old", rdata, {24'd0, m_led});
         @(negedge clk);
         rd = 1'b0; wr = 1'b0; addr = '0;
         m_led = rw[7:0];
         check("led_out", led, m_led);
         wr32(A_DIGI, rdg);
         m_digi = rdg[11:0];
         check("digi_out", digi, m_digi);
         rd32(A_DIGI, d); check("digi_rd", d, {20'd0, m_digi});
         rd32(A_SW, d);   check("sw_rd", d, {24'd0, switch});
         wr32(32'h4000_0044 + 32'(4 * $urandom_range(0, 15)), $urandom);
         rd32(32'h4000_0044, d); check("bad_addr_rd", d, 32'h0);
         rd32(A_TXD, d);  check("txd_rd_zero", d, 32'h0);
         check("led_hold", led, m_led);
         addr = A_LED; #1 check("rd_low_zero", rdata, 32'h0); addr = '0;
      end

      // Transmitter: fixed 2D case, ignored second write, then random bytes
      tx_frame(8'h2D, 1'b0, 2'b00);
      tx_frame(8'hC3, 1'b1, 2'b00);
      for (int t = 0; t < 4; t++) begin
         ie = 2'($urandom);
         b = 8'($urandom);
         wr32(A_UCON, {30'd0, ie});
         tx_frame(b, 1'($urandom), ie);
      end
      wr32(A_UCON, 32'h1);
      wr32(A_TXD, 32'h81);
      repeat (10 * BP) @(negedge clk);
      check("tx_irq_en", irqout, 1'b1);
      rd_clr(A_UCON, d);
      check("tx_irq_clr", irqout, 1'b0);
      wr32(A_UCON, 32'h0);

      // Timer: fixed reload case, then random reloads, both with and without interrupt
      timer_run(32'hFFFF_FFF0, 1, 3'b011, 5);
      for (int t = 0; t < 5; t++)
         timer_run($urandom_range(0, 32'h7FFF_FFFF), $urandom_range(0, 20),
                   ($urandom % 2) ? 3'b011 : 3'b001, $urandom_range(0, 10));

      // Receiver: random frames, some with a bad stop bit, some left unread to overwrite
      wr32(A_UCON, 32'h2);
      for (int t = 0; t < 8; t++) begin
         b = (t == 0) ? 8'h5A : 8'($urandom);
         stop = (t == 0) ? 1'b1 : ($urandom % 4 != 0);
         rx_send(b, stop);
         if (RX_EN && stop) begin m_rxd = b; m_ready = 1'b1; end
         rd32(A_UCON, d);
         check("rx_ready", d[3], m_ready);
         check("rx_irq", irqout, m_ready);
         if (t == 0 || ($urandom % 2)) begin
            rd_clr(A_RXD, d);
            check("rx_data", d, {24'd0, m_rxd});
            m_ready = 1'b0;
            check("rx_irq_clr", irqout, 1'b0);
         end else begin
            rd32(A_RXD, d);
            check("rx_data_peek", d, {24'd0, m_rxd});
         end
      end
      wr32(A_UCON, 32'h0);
      if (m_ready) begin
         rd_clr(A_RXD, d);
         m_ready = 1'b0;
      end

      // Reset in the middle of a frame
      wr32(A_LED, 32'h77);
      wr32(A_TXD, 32'h00);
      repeat (3 * BP) @(negedge clk);
      reset = 1'b0;
      #1;
      check("mid_rst_txd", txd, 1'b1);
      check("mid_rst_led", led, 8'h00);
      rd32(A_UCON, d);
      check("mid_rst_ucon", d, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      for (int t = 0; t < 8; t++) begin
         repeat (BP) @(negedge clk);
         check("post_rst_txd", txd, 1'b1);
      end
      rd32(A_UCON, d);
      check("post_rst_ucon", d, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/peripheral.md
PERIPHERAL -- requirements
Module: peripheral

Interface
REQ-001 Parameter: CLK_FREQ, 100000000, clk frequency in Hz.
REQ-002 Parameter: BAUD, 9600, UART bit rate; bit period BP = CLK_FREQ/BAUD clk cycles (integer division).
REQ-003 Port: clk  in  1  system clock; all state updates on its rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-low reset.
REQ-005 Port: rd  in  1  read strobe.
REQ-006 Port: wr  in  1  write strobe.
REQ-007 Port: addr  in  32  byte address of the register being accessed.
REQ-008 Port: wdata  in  32  write data.
REQ-009 Port: rdata  out  32  read data.
REQ-010 Port: led  out  8  LED register.
REQ-011 Port: switch  in  8  switch inputs.
REQ-012 Port: digi  out  12  seven-segment drive register.
REQ-013 Port: irqout  out  1  interrupt request.
REQ-014 Port: PC_Uart_rxd  in  1  UART receive line, idle high.
REQ-015 Port: PC_Uart_txd  out  1  UART transmit line, idle high.

Function
REQ-016 Address map, word aligned; addresses outside the map: reads return 0, writes are ignored:
- 40000000 TH (rw)
- 40000004 TL (rw)
- 40000008 TCON[2:0] (rw)
- 4000000C led (rw)
- 40000010 switch (ro)
- 40000014 digi (rw)
- 40000018 TXD[7:0] (wo, reads 0)
- 4000001C RXD[7:0] (ro)
- 40000020 UCON[4:0]
REQ-017 Reads SHALL be combinational: rdata is the addressed register, zero-extended, while rd=1; rdata is 0 when rd=0.
REQ-018 Writes SHALL take effect at the clk edge where wr=1. When rd and wr are both 1, the read returns the pre-write value.
REQ-019 Timer: while TCON[0]=1, TL increments every cycle. When TL=FFFFFFFF, TL SHALL load TH instead of incrementing, and TCON[2] SHALL be set if TCON[1]=1.
REQ-020 A CPU write to TL or TCON in the same cycle as a timer update SHALL win.
REQ-021 UCON bit meanings:
- [0] TX interrupt enable (rw)
- [1] RX interrupt enable (rw)
- [2] TX-done flag (ro; cleared by a read of UCON)
- [3] RX-ready flag (ro; cleared by a read of RXD)
- [4] TX busy (ro)
REQ-022 TX: a write to TXD while busy=0 SHALL latch wdata[7:0] and set busy on that edge. From the next cycle, txd sends an 8N1 frame, LSB first, holding each bit for BP cycles: start 0, 8 data bits, stop 1.
REQ-023 At the end of the stop bit, busy SHALL clear and TX-done SHALL set. A TXD write while busy=1 SHALL be ignored.
REQ-024 RX: a falling edge on the synchronized rxd (2-flop synchronizer) SHALL start a frame.
REQ-025 RX sampling: rxd is sampled at BP/2 into the start bit; if the line is high there, the frame is aborted. Each data bit and the stop bit are sampled at BP intervals after that.
REQ-026 RX completion: if the stop bit samples 1, the byte SHALL be written to RXD and RX-ready set. If the stop bit samples 0, the frame SHALL be discarded.
REQ-027 A new received byte SHALL overwrite an unread RXD. If a RXD read and a byte completion occur in the same cycle, RX-ready stays set.
REQ-028 irqout = TCON[2] | (UCON[0] & TX-done) | (UCON[1] & RX-ready), combinational from registers.

Reset
REQ-029 While reset=0, the following SHALL be held at their reset values, asynchronously: TH, TL, TCON, led, digi, RXD, UCON, all FSMs idle, txd=1, irqout=0.
REQ-030 All reset values are 0 except txd, which is 1. Reset mid-frame aborts the frame without emitting further bits.

Configuration
REQ-031 Macro PERIPHERAL_UART_RX_EN: when defined, the receiver of REQ-024..027 is built. When undefined, PC_Uart_rxd is ignored, RXD reads 0, and UCON[3] is constant 0.

Verification
REQ-032 Reset pulse low then high -> led=00, digi=000, txd=1, irqout=0, and reads of TH/TL/TCON/UCON return 0.
REQ-033 Write 0000002D to 40000018 for one cycle -> UCON[4]=1; txd emits 0 then 1,0,1,1,0,1,0,0 then 1, each bit BP cycles; then UCON[4]=0 and UCON[2]=1.
REQ-034 Write TH=FFFFFFF0, TL=FFFFFFFE, TCON=3 -> irqout rises 2 cycles later, TL=FFFFFFF0, and TL keeps counting from there.
REQ-035 Write A5 to 4000000C, switch=3C, read 40000010 -> led=A5, rdata=0000003C; a read of 40000044 returns 0.
REQ-036 With the RX macro defined, UCON=2 and frame 5A driven on rxd -> RX-ready=1, irqout=1; reading 4000001C returns 5A and clears irqout.
REQ-037 Second TXD write (value 55) during an active frame -> ignored; the frame in progress completes unchanged.
